// File: rtl/decode_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decode_hazard_ctrl_if                                         |
// | Purpose  : Bundles the decode-stage handshake between the decode stage   |
// |            (master) and the RAW hazard controller (slave).               |
// | Signals  : ID_Valid, ID_ReadReg1/2, ID_Read1En/2En, ID_WriteReg,         |
// |            ID_RegWrite, ID_Halt, Flush   -> controller                   |
// |            Stall, Issue, Busy, Halted, StallCnt[CNT_W]  <- controller    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface decode_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_Valid;
    logic [2:0]       ID_ReadReg1;
    logic [2:0]       ID_ReadReg2;
    logic             ID_Read1En;
    logic             ID_Read2En;
    logic [2:0]       ID_WriteReg;
    logic             ID_RegWrite;
    logic             ID_Halt;
    logic             Flush;
    logic             Stall;
    logic             Issue;
    logic             Busy;
    logic             Halted;
    logic [CNT_W-1:0] StallCnt;

    // Decode-stage side
    modport master (
        output ID_Valid, ID_ReadReg1, ID_ReadReg2, ID_Read1En, ID_Read2En,
        output ID_WriteReg, ID_RegWrite, ID_Halt, Flush,
        input  Stall, Issue, Busy, Halted, StallCnt
    );

    // Hazard-controller side
    modport slave (
        input  ID_Valid, ID_ReadReg1, ID_ReadReg2, ID_Read1En, ID_Read2En,
        input  ID_WriteReg, ID_RegWrite, ID_Halt, Flush,
        output Stall, Issue, Busy, Halted, StallCnt
    );
endinterface
`default_nettype wire

// File: rtl/decode_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decode_hazard_ctrl                                            |
// | Purpose  : Scoreboard-based RAW hazard control for the decode stage.     |
// |            Tracks destinations of instructions in EX/MEM/WB, stalls a    |
// |            decode instruction that reads one of them, and sequences a    |
// |            halt through RUN -> DRAIN -> HALTED.                          |
// | Ports    : clk  - single clock, rising edge                              |
// |            rst  - asynchronous, active-low reset                         |
// |            bus  - decode_hazard_ctrl_if.slave (decode request inputs,    |
// |                   Stall/Issue/Busy/Halted/StallCnt outputs)              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module decode_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_DRAIN  = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    // Scoreboard: slot 0 = EX, slot 1 = MEM, slot 2 = WB
    logic [2:0]       r_slotV;
    logic [2:0]       r_slotDst [0:2];
    logic [1:0]       r_state;
    logic [1:0]       r_drainCnt;
    logic [CNT_W-1:0] r_stallCnt;

    logic [1:0]       w_nextState;
    logic [1:0]       w_nextDrainCnt;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_run;
    logic             w_stall;
    logic             w_issue;
    logic             w_halted;

    // WB still counts as a hazard: the register file has no write-through.
    always_comb begin
        w_hit1 = (r_slotV[0] && (r_slotDst[0] == bus.ID_ReadReg1)) ||
                 (r_slotV[1] && (r_slotDst[1] == bus.ID_ReadReg1)) ||
                 (r_slotV[2] && (r_slotDst[2] == bus.ID_ReadReg1));
        w_hit2 = (r_slotV[0] && (r_slotDst[0] == bus.ID_ReadReg2)) ||
                 (r_slotV[1] && (r_slotDst[1] == bus.ID_ReadReg2)) ||
                 (r_slotV[2] && (r_slotDst[2] == bus.ID_ReadReg2));
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_RUN;
            r_drainCnt <= 2'd0;
        end else begin
            r_state    <= w_nextState;
            r_drainCnt <= w_nextDrainCnt;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    // The halt enters EX on the issuing edge; three further edges carry it
    // through EX, MEM and WB, so the third DRAIN edge lands in HALTED.
    always_comb begin
        w_nextState    = r_state;
        w_nextDrainCnt = r_drainCnt;
        case (r_state)
            c_RUN: begin
                if (w_issue && bus.ID_Halt) begin
                    w_nextState    = c_DRAIN;
                    w_nextDrainCnt = 2'd0;
                end
            end
            c_DRAIN: begin
                w_nextDrainCnt = r_drainCnt + 2'd1;
                if (r_drainCnt == 2'd2) begin
                    w_nextState = c_HALTED;
                end
            end
            c_HALTED: begin
                w_nextState = c_HALTED;
            end
            default: begin
                w_nextState    = c_RUN;
                w_nextDrainCnt = 2'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    // Flush masks both Stall and Issue; a wrong-path instruction never waits.
    always_comb begin
        w_run    = (r_state == c_RUN);
        w_halted = (r_state == c_HALTED);
        w_stall  = bus.ID_Valid && !bus.Flush && w_run &&
                   ((bus.ID_Read1En && w_hit1) || (bus.ID_Read2En && w_hit2));
        w_issue  = bus.ID_Valid && !bus.Flush && !w_stall && w_run;
    end

    // ---------------------------------------------------------------- scoreboard and counter
    // Slots shift every edge, even on flush; a stalled cycle loads a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slotV      <= 3'b000;
            r_slotDst[0] <= 3'd0;
            r_slotDst[1] <= 3'd0;
            r_slotDst[2] <= 3'd0;
            r_stallCnt   <= '0;
        end else begin
            r_slotV[2]   <= r_slotV[1];
            r_slotDst[2] <= r_slotDst[1];
            r_slotV[1]   <= r_slotV[0];
            r_slotDst[1] <= r_slotDst[0];
            if (w_issue && bus.ID_RegWrite) begin
                r_slotV[0]   <= 1'b1;
                r_slotDst[0] <= bus.ID_WriteReg;
            end else begin
                r_slotV[0]   <= 1'b0;
                r_slotDst[0] <= 3'd0;
            end
            if (w_stall && (r_stallCnt != {CNT_W{1'b1}})) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    assign bus.Stall    = w_stall;
    assign bus.Issue    = w_issue;
    assign bus.Busy     = |r_slotV;
    assign bus.Halted   = w_halted;
    assign bus.StallCnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_decode_hazard_ctrl                                         |
// | Purpose  : Self-checking bench for decode_hazard_ctrl. A timestamp model |
// |            (edge number of each register's last write, edge of halt      |
// |            issue) predicts all outputs every cycle; directed sequences   |
// |            add hand-computed literal checks.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_decode_hazard_ctrl;

    localparam int CNT_W = 2;
    localparam int c_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    decode_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int passCnt  = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------ model
    // A register is pending while fewer than 3 edges have passed since the
    // edge that issued its writer.
    int edgeCount = 0;
    int lastWr [8];
    bit haltSeen  = 1'b0;
    int haltEdge  = 0;
    int mCnt      = 0;

    function automatic bit mHit(input logic [2:0] r);
        return (edgeCount - lastWr[r]) < 3;
    endfunction

    function automatic bit mRun();
        return !haltSeen;
    endfunction

    function automatic bit mHalted();
        return haltSeen && ((edgeCount - haltEdge) >= 3);
    endfunction

    function automatic bit expStall();
        return bus.ID_Valid && !bus.Flush && mRun() &&
               ((bus.ID_Read1En && mHit(bus.ID_ReadReg1)) ||
                (bus.ID_Read2En && mHit(bus.ID_ReadReg2)));
    endfunction

    function automatic bit expIssue();
        return bus.ID_Valid && !bus.Flush && !expStall() && mRun();
    endfunction

    function automatic bit expBusy();
        bit b = 1'b0;
        for (int r = 0; r < 8; r++) if (mHit(3'(r))) b = 1'b1;
        return b;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edgeCount <= 0;
            haltSeen  <= 1'b0;
            haltEdge  <= 0;
            mCnt      <= 0;
            for (int r = 0; r < 8; r++) lastWr[r] <= -100;
        end else begin
            if (expStall() && (mCnt < c_MAX)) mCnt <= mCnt + 1;
            if (expIssue() && bus.ID_RegWrite) lastWr[bus.ID_WriteReg] <= edgeCount + 1;
            if (expIssue() && bus.ID_Halt) begin
                haltSeen <= 1'b1;
                haltEdge <= edgeCount + 1;
            end
            edgeCount <= edgeCount + 1;
        end
    end

    // ------------------------------------------------------------ per-cycle compare
    always @(negedge clk) begin
        check("m_Stall",    32'(bus.Stall),    32'(expStall()));
        check("m_Issue",    32'(bus.Issue),    32'(expIssue()));
        check("m_Busy",     32'(bus.Busy),     32'(expBusy()));
        check("m_Halted",   32'(bus.Halted),   32'(mHalted()));
        check("m_StallCnt", 32'(bus.StallCnt), 32'(mCnt));
    end

    // ------------------------------------------------------------ stimulus
    task automatic drv(input int v, input int r1, input int e1, input int r2, input int e2,
                       input int wr, input int rw, input int halt, input int fl);
        bus.ID_Valid    = 1'(v);
        bus.ID_ReadReg1 = 3'(r1);
        bus.ID_Read1En  = 1'(e1);
        bus.ID_ReadReg2 = 3'(r2);
        bus.ID_Read2En  = 1'(e2);
        bus.ID_WriteReg = 3'(wr);
        bus.ID_RegWrite = 1'(rw);
        bus.ID_Halt     = 1'(halt);
        bus.Flush       = 1'(fl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nStall;
        int n;
        int busyOk;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        check("rst_Busy",     32'(bus.Busy),     32'd0);
        check("rst_Halted",   32'(bus.Halted),   32'd0);
        check("rst_StallCnt", 32'(bus.StallCnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Back-to-back RAW on r3
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
        #1 check("raw_prod_issue", 32'(bus.Issue), 32'd1);
        tick();
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        #1 check("raw_first_stall", 32'(bus.Stall), 32'd1);
        nStall = 0;
        n = 0;
        while (bus.Issue !== 1'b1 && n < 10) begin
            if (bus.Stall === 1'b1) nStall++;
            tick();
            #1;
            n++;
        end
        check("raw_issue_seen",  32'(n < 10),        32'd1);
        check("raw_stall_count", 32'(nStall),        32'd3);
        check("raw_StallCnt",    32'(bus.StallCnt),  32'd3);
        tick();

        // Independent stream r1..r6, reading r0/r7
        idle(3);
        nStall = 0;
        busyOk = 1;
        for (int i = 1; i <= 6; i++) begin
            drv(1, 0, 1, 7, 1, i, 1, 0, 0);
            #1;
            if (bus.Stall === 1'b1) nStall++;
            if (i > 1 && bus.Busy !== 1'b1) busyOk = 0;
            tick();
        end
        check("ind_no_stall", 32'(nStall), 32'd0);
        check("ind_busy",     32'(busyOk), 32'd1);

        // Flush while r2 sits in MEM
        idle(3);
        drv(1, 0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        idle(1);
        drv(1, 2, 1, 0, 0, 0, 0, 0, 1);
        #1;
        check("flush_stall", 32'(bus.Stall), 32'd0);
        check("flush_issue", 32'(bus.Issue), 32'd0);
        check("flush_busy",  32'(bus.Busy),  32'd1);
        tick();
        drv(1, 2, 1, 0, 0, 0, 0, 0, 0);
        #1 check("flush_wb_stall", 32'(bus.Stall), 32'd1);
        tick();
        #1 check("flush_then_issue", 32'(bus.Issue), 32'd1);
        tick();

        // Flushed halt must not start DRAIN
        idle(3);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 check("flushhalt_issue", 32'(bus.Issue), 32'd0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
        #1 check("flushhalt_still_run", 32'(bus.Issue), 32'd1);
        tick();

        // Halt, then asynchronous reset mid-DRAIN
        idle(3);
        drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
        #1 check("halt_issue", 32'(bus.Issue), 32'd1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("drain_no_issue", 32'(bus.Issue), 32'd0);
        check("drain_busy",     32'(bus.Busy),  32'd1);
        tick();
        #1 rst = 1'b0;
        #1;
        check("arst_Halted",   32'(bus.Halted),   32'd0);
        check("arst_Busy",     32'(bus.Busy),     32'd0);
        check("arst_StallCnt", 32'(bus.StallCnt), 32'd0);
        check("arst_run",      32'(bus.Issue),    32'd1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Saturation: consumer of r4 that also rewrites r4
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
        tick();
        drv(1, 4, 1, 0, 0, 4, 1, 0, 0);
        nStall = 0;
        n = 0;
        while (nStall < 5 && n < 20) begin
            #1;
            if (bus.Stall === 1'b1) nStall++;
            tick();
            n++;
        end
        #1;
        check("sat_stalls",   32'(nStall),       32'd5);
        check("sat_StallCnt", 32'(bus.StallCnt), 32'd3);

        // Halt blocked by a hazard, then drains to HALTED
        idle(3);
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 1, 0);
        #1 check("halt_stalled", 32'(bus.Stall), 32'd1);
        n = 0;
        while (bus.Issue !== 1'b1 && n < 10) begin
            tick();
            #1;
            n++;
        end
        check("halt_wait_cycles", 32'(n), 32'd3);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 check("drain_not_halted", 32'(bus.Halted), 32'd0);
            tick();
        end
        #1;
        check("halted_set",   32'(bus.Halted), 32'd1);
        check("halted_issue", 32'(bus.Issue),  32'd0);
        repeat (3) tick();
        #1;
        check("halted_sticky", 32'(bus.Halted), 32'd1);
        check("halted_nostall", 32'(bus.Stall), 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
